// File: rtl/asynch_edge_detect.sv
// -----------------------------------------------------------------------------
// asynch_edge_detect
//
// Brings an asynchronous level into the SYNC_CLK_IN domain through a plain
// flop chain, then emits a registered one-cycle pulse on the selected edge of
// the synchronized level. An optional counter tallies the emitted pulses.
//
// Parameters
//   SYNC_STAGES     number of synchronizer flops (2..4)
//   EDGE_MODE       0 rising, 1 falling, 2 both; any other value acts as 0
//   CNT_W           width of the pulse counter
//
// Ports
//   SYNC_CLK_IN     sole clock, all flops on its rising edge
//   RESET_N_IN      synchronous active-low reset
//   ASYNC_IN        asynchronous input level
//   SYNC_OUT        registered one-cycle pulse per selected edge
//   SYNC_LEVEL_OUT  synchronized level (last synchronizer stage)
//   EDGE_COUNT_OUT  number of SYNC_OUT pulses seen, wraps at 2^CNT_W
//
// Build option
//   ASYNC_EDGE_COUNT_EN  when defined, EDGE_COUNT_OUT counts pulses;
//                        otherwise it is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module asynch_edge_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 16
) (
    input  logic             SYNC_CLK_IN,
    input  logic             RESET_N_IN,
    input  logic             ASYNC_IN,
    output logic             SYNC_OUT,
    output logic             SYNC_LEVEL_OUT,
    output logic [CNT_W-1:0] EDGE_COUNT_OUT
);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_sel_e;

    // Out-of-range modes collapse onto rising-edge detection.
    localparam edge_sel_e EDGE_SEL = (EDGE_MODE == 1) ? EDGE_FALL :
                                     (EDGE_MODE == 2) ? EDGE_BOTH :
                                                        EDGE_RISE;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("asynch_edge_detect: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out_q;
    logic                   sync_out_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Bare flop chain: only stage 0 sees ASYNC_IN, nothing between stages.
    always_ff @(posedge SYNC_CLK_IN) begin
        if (!RESET_N_IN) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            sync_out_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
            prev_q     <= level;
            sync_out_q <= sync_out_d;
        end
    end

    always_comb begin
        sync_out_d = 1'b0;
        unique case (EDGE_SEL)
            EDGE_FALL: sync_out_d = ~level & prev_q;
            EDGE_BOTH: sync_out_d = level ^ prev_q;
            default:   sync_out_d = level & ~prev_q;
        endcase
    end

    assign SYNC_OUT       = sync_out_q;
    assign SYNC_LEVEL_OUT = level;

`ifdef ASYNC_EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counts the registered pulse, so the count moves one cycle after SYNC_OUT.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(sync_out_q);
    end

    always_ff @(posedge SYNC_CLK_IN) begin
        if (!RESET_N_IN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign EDGE_COUNT_OUT = cnt_q;
`else
    assign EDGE_COUNT_OUT = '0;
`endif

endmodule

// File: tb/tb_asynch_edge_detect.sv
// -----------------------------------------------------------------------------
// tb_asynch_edge_detect
//
// Five instances with different stage counts, edge modes and counter widths
// share one clock, reset and input. The reference model describes the outputs
// directly as delayed views of the sampled input history: the synchronized
// level is the input N-1 edges back (zero if any reset fell in that window),
// a pulse is the selected edge between consecutive synchronized levels, and
// the count is the running tally of pulses.
// -----------------------------------------------------------------------------
module tb_asynch_edge_detect;

    localparam int ND   = 5;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;

    logic [ND-1:0] p_o;
    logic [ND-1:0] l_o;
    logic [15:0]   c0;
    logic [3:0]    c1;
    logic [15:0]   c2;
    logic [7:0]    c3;
    logic [15:0]   c4;

    int NS[ND] = '{2, 3, 2, 4, 2};
    int MD[ND] = '{0, 0, 2, 1, 3};
    int CW[ND] = '{16, 4, 16, 8, 16};

    bit     in_h[MAXC];
    bit     rst_h[MAXC];
    int     cyc = 0;
    longint exp_cnt[ND];
    int     win_p[ND];
    int     total = 0;
    int     bad = 0;

    always #25 clk = ~clk;

    asynch_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(0), .CNT_W(16)) u_d0 (
        .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .ASYNC_IN(a),
        .SYNC_OUT(p_o[0]), .SYNC_LEVEL_OUT(l_o[0]), .EDGE_COUNT_OUT(c0));
    asynch_edge_detect #(.SYNC_STAGES(3), .EDGE_MODE(0), .CNT_W(4)) u_d1 (
        .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .ASYNC_IN(a),
        .SYNC_OUT(p_o[1]), .SYNC_LEVEL_OUT(l_o[1]), .EDGE_COUNT_OUT(c1));
    asynch_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(2), .CNT_W(16)) u_d2 (
        .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .ASYNC_IN(a),
        .SYNC_OUT(p_o[2]), .SYNC_LEVEL_OUT(l_o[2]), .EDGE_COUNT_OUT(c2));
    asynch_edge_detect #(.SYNC_STAGES(4), .EDGE_MODE(1), .CNT_W(8)) u_d3 (
        .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .ASYNC_IN(a),
        .SYNC_OUT(p_o[3]), .SYNC_LEVEL_OUT(l_o[3]), .EDGE_COUNT_OUT(c3));
    asynch_edge_detect #(.SYNC_STAGES(2), .EDGE_MODE(3), .CNT_W(16)) u_d4 (
        .SYNC_CLK_IN(clk), .RESET_N_IN(rst_n), .ASYNC_IN(a),
        .SYNC_OUT(p_o[4]), .SYNC_LEVEL_OUT(l_o[4]), .EDGE_COUNT_OUT(c4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Synchronized level after edge t: input from N-1 edges earlier, unless a
    // reset was sampled anywhere in that window.
    function automatic bit m_lvl(int n, int t);
        if (t < 1) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (t - i < 1 || rst_h[t-i]) return 1'b0;
        end
        return in_h[t-n+1];
    endfunction

    // Level from the previous edge, as held in the history flop after edge t.
    function automatic bit m_prev(int n, int t);
        if (t < 1 || rst_h[t]) return 1'b0;
        return m_lvl(n, t - 1);
    endfunction

    function automatic bit m_pulse(int n, int mode, int t);
        bit cur, old;
        if (t < 1 || rst_h[t]) return 1'b0;
        cur = m_lvl(n, t - 1);
        old = m_prev(n, t - 1);
        case (mode)
            1:       return ~cur & old;
            2:       return cur ^ old;
            default: return cur & ~old;
        endcase
    endfunction

    function automatic logic [31:0] cnt_of(int d);
        case (d)
            0:       return 32'(c0);
            1:       return 32'(c1);
            2:       return 32'(c2);
            3:       return 32'(c3);
            default: return 32'(c4);
        endcase
    endfunction

    task automatic check_all();
        longint mask;
        bit     ep;
        for (int d = 0; d < ND; d++) begin
            mask = (longint'(1) << CW[d]) - 1;
            if (rst_h[cyc]) exp_cnt[d] = 0;
            else            exp_cnt[d] = (exp_cnt[d] + longint'(m_pulse(NS[d], MD[d], cyc - 1))) & mask;
            ep = m_pulse(NS[d], MD[d], cyc);
            chk($sformatf("lvl%0d", d), 32'(l_o[d]), 32'(m_lvl(NS[d], cyc)));
            chk($sformatf("pulse%0d", d), 32'(p_o[d]), 32'(ep));
`ifdef ASYNC_EDGE_COUNT_EN
            chk($sformatf("cnt%0d", d), cnt_of(d), 32'(exp_cnt[d]));
`else
            chk($sformatf("cnt%0d", d), cnt_of(d), 32'd0);
`endif
            win_p[d] += int'(p_o[d]);
        end
    endtask

    // One clock: record what the edge sampled, drive the next inputs
    // mid-cycle, then check the outputs on the falling edge.
    task automatic step(input bit r, input bit v, input bit drive_a);
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp<%0d", cyc, cyc, MAXC);
            $display("test done: total=%0d bad=%0d", total, bad + 1);
            $fatal(1);
        end
        in_h[cyc]  = a;
        rst_h[cyc] = ~rst_n;
        #10;
        rst_n = r;
        if (drive_a) a = v;
        #15;
        check_all();
    endtask

    task automatic clear_win();
        for (int d = 0; d < ND; d++) win_p[d] = 0;
    endtask

    initial begin
        int rst_left;
        bit v;
        rst_h[0] = 1'b1;
        for (int d = 0; d < ND; d++) exp_cnt[d] = 0;
        clear_win();

        // Power-up reset.
        repeat (4) step(1'b0, 1'b0, 1'b1);
        chk("rst_pulse", 32'(p_o[0]), 32'd0);
        chk("rst_cnt", 32'(c0), 32'd0);

        // Reset released with input high: treated as a rising edge.
        step(1'b1, 1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("pre_rst_pulse", 32'(p_o[0]), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst_pulse", 32'(p_o[0]), 32'd0);
        chk("mid_rst_cnt", 32'(c0), 32'd0);
        clear_win();
        repeat (8) step(1'b1, 1'b1, 1'b1);
        chk("post_rst_rises", 32'(win_p[0]), 32'd1);

        // Randomized input with occasional short resets.
        rst_left = 0;
        v = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 99) < 2) rst_left = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) v = ~v;
            step(rst_left == 0, v, 1'b1);
        end

        // 17 rising edges from a fresh reset: the 4-bit counter wraps to 1.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (17) begin
            repeat (3) step(1'b1, 1'b1, 1'b1);
            repeat (3) step(1'b1, 1'b0, 1'b1);
        end
        repeat (6) step(1'b1, 1'b0, 1'b1);
`ifdef ASYNC_EDGE_COUNT_EN
        chk("wrap_cnt", 32'(c1), 32'd1);
`else
        chk("wrap_cnt", 32'(c1), 32'd0);
`endif

        // Free-running 128-time-unit input against the 50-unit clock.
        // Toggles land on even times, clock edges on odd times.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        clear_win();
        fork
            begin
                #14;
                repeat (20) begin
                    a = ~a;
                    #64;
                end
            end
            begin
                repeat (34) step(1'b1, 1'b0, 1'b0);
            end
        join
        chk("async_rises", 32'(win_p[0]), 32'd10);
        chk("async_toggles", 32'(win_p[2]), 32'd20);
        chk("async_falls", 32'(win_p[3]), 32'd10);
`ifdef ASYNC_EDGE_COUNT_EN
        chk("async_cnt", 32'(c2), 32'd20);
`else
        chk("async_cnt", 32'(c2), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
